// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and the write-request record for the register-file write path.
//   ADDR_W/DATA_W : register index and data widths
//   NUM_REGS      : number of architectural registers
//   REG_ZERO      : hardwired-zero register index, never written
//   wr_req_t      : {idx, data} write request
package regfile_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/wb_req_fifo.sv
// wb_req_fifo: synchronous FIFO of write requests buffering long-latency unit results.
//   clk, reset : clock, async active-high reset (empties the FIFO)
//   push, din  : write din at the tail (caller guarantees !full)
//   pop        : drop the head entry (caller guarantees !empty)
//   full/empty : occupancy flags
//   head       : oldest entry, valid when !empty
module wb_req_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  wr_req_t din,
    output logic    full,
    output logic    empty,
    output wr_req_t head
);
    localparam int PW = $clog2(DEPTH);
    wr_req_t mem [DEPTH];
    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head = mem[rd_ptr[PW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= din;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the register-file write port, arbitrating W stage vs buffered LU results.
//   clk, reset                 : clock, async active-high reset
//   wb_valid/wb_reg/wb_data    : W stage write request (no backpressure)
//   wb_stall                   : W request not granted this cycle
//   lu_valid/lu_reg/lu_data    : LU result, accepted when lu_ready
//   lu_ready                   : FIFO has room
//   issue_valid/issue_reg      : LU op issuing, marks its destination busy
//   src_a/src_b, busy_a/busy_b : decode sources and their outstanding-LU-write flags
//   rf_we/rf_waddr/rf_wdata    : registered register-file write port
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_reg,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic                fifo_full, fifo_empty, push, pop, force_lu, grant_wb, sel_we;
    logic [SW-1:0]       starve;
    logic [NUM_REGS-1:0] sb, sb_next;
    wr_req_t             lu_req, wb_req, head, sel;

    assign lu_req.idx = lu_reg;
    assign lu_req.data = lu_data;
    assign wb_req.idx = wb_reg;
    assign wb_req.data = wb_data;

    wb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (lu_req),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // lu_ready looks only at current occupancy, so a full FIFO refuses a push even while popping.
    assign lu_ready = !fifo_full;
    assign push = lu_valid && lu_ready;
    assign force_lu = !fifo_empty && (starve == STARVE_LIM);
    assign wb_stall = force_lu && wb_valid;
    assign grant_wb = wb_valid && !force_lu;
    assign pop = !fifo_empty && !grant_wb;
    assign sel = grant_wb ? wb_req : head;
    // Requests to the zero register are consumed but never reach the register file.
    assign sel_we = (grant_wb || pop) && (sel.idx != REG_ZERO);
    assign busy_a = sb[src_a];
    assign busy_b = sb[src_b];

    // Clear on pop first so a same-cycle issue to the same register wins.
    always_comb begin
        sb_next = sb;
        if (pop) sb_next[head.idx] = 1'b0;
        if (issue_valid) sb_next[issue_reg] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve <= '0;
            sb <= '0;
            rf_we <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            sb <= sb_next;
            if (fifo_empty || pop) starve <= '0;
            else if (grant_wb && starve != STARVE_LIM) starve <= starve + 1'b1;
            rf_we <= sel_we;
            if (sel_we) begin
                rf_waddr <= sel.idx;
                rf_wdata <= sel.data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random checks of the write arbiter against a queue-based model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_valid, lu_valid, issue_valid;
    logic [ADDR_W-1:0] wb_reg, lu_reg, issue_reg, src_a, src_b;
    logic [DATA_W-1:0] wb_data, lu_data;
    logic              wb_stall, lu_ready, busy_a, busy_b, rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    int errors = 0;
    int checks = 0;

    wr_req_t           q[$];
    int                starve;
    bit [NUM_REGS-1:0] msb;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    regfile_write_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .wb_stall    (wb_stall),
        .lu_valid    (lu_valid),
        .lu_reg      (lu_reg),
        .lu_data     (lu_data),
        .lu_ready    (lu_ready),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        starve = 0;
        msb = '0;
        exp_we = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model, check the write port.
    task automatic cyc(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ir, input logic [4:0] sa, input logic [4:0] sbr);
        wr_req_t     e;
        logic        rdy, frc, g;
        logic [4:0]  gi;
        logic [31:0] gd;
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        lu_valid = lv; lu_reg = lr; lu_data = ld;
        issue_valid = iv; issue_reg = ir; src_a = sa; src_b = sbr;
        #1;
        rdy = q.size() < FIFO_DEPTH;
        frc = (q.size() != 0) && (starve == STARVE_MAX);
        chk("lu_ready", 32'(lu_ready), 32'(rdy));
        chk("wb_stall", 32'(wb_stall), 32'(frc && wv));
        chk("busy_a", 32'(busy_a), 32'(msb[sa]));
        chk("busy_b", 32'(busy_b), 32'(msb[sbr]));
        g = 1'b0; gi = '0; gd = '0;
        if (wv && !frc) begin
            g = 1'b1; gi = wr; gd = wd;
            if (q.size() != 0 && starve < STARVE_MAX) starve++;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            g = 1'b1; gi = e.idx; gd = e.data;
            starve = 0;
            msb[e.idx] = 1'b0;
        end
        if (q.size() == 0) starve = 0;
        if (lv && rdy) begin
            e.idx = lr; e.data = ld;
            q.push_back(e);
        end
        if (iv && ir != 0) msb[ir] = 1'b1;
        exp_we = g && (gi != 0);
        if (exp_we) begin
            exp_addr = gi;
            exp_data = gd;
        end
        @(posedge clk);
        #1;
        chk("rf_we", 32'(rf_we), 32'(exp_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(exp_addr));
        chk("rf_wdata", rf_wdata, exp_data);
    endtask

    initial begin
        reset = 1'b1;
        wb_valid = 0; wb_reg = 0; wb_data = 0;
        lu_valid = 0; lu_reg = 0; lu_data = 0;
        issue_valid = 0; issue_reg = 0; src_a = 0; src_b = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_lu_ready", 32'(lu_ready), 32'd1);
        chk("rst_wb_stall", 32'(wb_stall), 32'd0);
        reset = 1'b0;

        // W-only stream
        for (int i = 0; i < 4; i++) cyc(1, 5'(5 + i), 32'hA0 + 32'(i), 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // LU-only: issue 9, see busy, push result, see it written and busy cleared
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        chk("lu_busy_set", 32'(msb[9]), 32'd1);
        cyc(0, 0, 0, 1, 9, 32'hDEAD, 0, 0, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        chk("lu_write_addr", 32'(rf_waddr), 32'd9);
        chk("lu_write_data", rf_wdata, 32'hDEAD);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);

        // Starvation: W held busy while reg 3 sits in the FIFO
        cyc(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        cyc(1, 10, 32'h100, 1, 3, 32'h333, 0, 0, 3, 0);
        for (int i = 0; i < 5; i++) cyc(1, 5'(11 + i), 32'h200 + 32'(i), 0, 0, 0, 0, 0, 3, 0);

        // FIFO full: two pushes while W busy, then a held push waits for a pop
        cyc(1, 20, 32'h300, 1, 21, 32'h211, 1, 21, 21, 22);
        cyc(1, 20, 32'h301, 1, 22, 32'h222, 1, 22, 21, 22);
        for (int i = 0; i < 8; i++) cyc(1, 20, 32'h302 + 32'(i), 1, 23, 32'h233, 0, 0, 21, 23);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 22, 23);

        // Register 0 from both sides and an issue to 0
        cyc(1, 0, 32'hBAD0, 1, 0, 32'hBAD1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        // Reset mid-operation: drain, set busy 4/7, fill FIFO, then reset between edges
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 4, 4, 7);
        cyc(1, 1, 32'h11, 1, 4, 32'h44, 1, 7, 4, 7);
        cyc(1, 2, 32'h22, 1, 7, 32'h77, 0, 0, 4, 7);
        chk("pre_rst_full", 32'(lu_ready), 32'd0);
        chk("pre_rst_busy_a", 32'(busy_a), 32'd1);
        chk("pre_rst_busy_b", 32'(busy_b), 32'd1);
        wb_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_we", 32'(rf_we), 32'd0);
        chk("arst_waddr", 32'(rf_waddr), 32'd0);
        chk("arst_wdata", rf_wdata, 32'd0);
        chk("arst_lu_ready", 32'(lu_ready), 32'd1);
        chk("arst_wb_stall", 32'(wb_stall), 32'd0);
        chk("arst_busy_a", 32'(busy_a), 32'd0);
        chk("arst_busy_b", 32'(busy_b), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 4, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single register-file write port.
- Arbitrates between two requesters:
  - the in-order pipeline writeback stage (W), which has no backpressure and is held via `wb_stall`;
  - the long-latency mult/div unit (LU), which uses a valid/ready handshake.
- Buffers LU results in a small FIFO.
- Keeps a scoreboard of destination registers with outstanding LU results, so issue logic can stall on RAW hazards.
- Sits between the W stage / LU and registerFile.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers)
- FIFO_DEPTH, 2, LU result buffer entries (power of 2, ≥2)
- STARVE_MAX, 3, cycles a non-empty FIFO head may lose arbitration before it is forced

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- wb_valid  input  1  W stage has a result to write this cycle
- wb_reg  input  ADDR_W  W destination register
- wb_data  input  DATA_W  W result (ALU or memory data, already muxed)
- wb_stall  output  1  W request not granted this cycle; pipeline must hold W stage
- lu_valid  input  1  LU result available
- lu_reg  input  ADDR_W  LU destination register
- lu_data  input  DATA_W  LU result
- lu_ready  output  1  FIFO can accept an LU result
- issue_valid  input  1  an LU operation issues this cycle
- issue_reg  input  ADDR_W  destination of the issuing LU operation
- src_a  input  ADDR_W  source register A of the instruction in decode
- src_b  input  ADDR_W  source register B of the instruction in decode
- busy_a  output  1  src_a has an outstanding LU write
- busy_b  output  1  src_b has an outstanding LU write
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  ADDR_W  register-file write index (registered)
- rf_wdata  output  DATA_W  register-file write data (registered)

Behaviour:
- Reset (async, immediate):
  - FIFO emptied, starve counter 0, scoreboard all 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - lu_ready=1, wb_stall=0, busy_a/b=0.
  - Pending LU results are dropped; the LU must also be reset.
- LU handshake:
  - lu_ready = !full, computed from current state only.
  - A push occurs when lu_valid && lu_ready.
  - No push into a full FIFO, even in a cycle where it pops.
  - An LU result takes at least one cycle in the FIFO; no bypass.
- Grant, combinational each cycle:
  - force = fifo_nonempty && (starve == STARVE_MAX).
  - If force: FIFO head granted; wb_stall = wb_valid.
  - Else if wb_valid: W granted, wb_stall=0.
  - Else if fifo_nonempty: FIFO head granted (pop).
  - Else: idle.
- Starve counter:
  - Increments when the FIFO is non-empty and W is granted.
  - Resets to 0 on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- Write port:
  - Granted request registers into rf_we/rf_waddr/rf_wdata at the next edge (latency 1 cycle).
  - rf_we=0 in idle cycles; rf_waddr/rf_wdata hold their previous values.
  - Any request with reg==0 is consumed (popped/acknowledged) but produces rf_we=0.
- Scoreboard (32 bits):
  - Set bit issue_reg on issue_valid when issue_reg!=0.
  - Clear bit lu_reg on FIFO pop of that entry.
  - Same-cycle set and clear of the same register: set wins.
  - Bit 0 is always 0.
  - busy_a = sb[src_a], busy_b = sb[src_b]: combinational from registered state; a same-cycle set is not visible until the next cycle.
- Not checked by this block:
  - WAW between W and outstanding LU writes (owned by issue logic via busy_*).
  - LU results whose register was never issued.

Decomposition:
- Package regfile_pkg:
  - ADDR_W, DATA_W, NUM_REGS=32, REG_ZERO=0.
  - Struct wr_req_t {reg idx, data}.
- Sub-module wb_req_fifo:
  - Parameterised synchronous FIFO of wr_req_t.
  - Ports: push, pop, full, empty, head.
  - Async active-high reset.
- Arbiter, starve counter, scoreboard and output register live in the top.

Test Plan:
- W-only stream: wb_valid=1, reg 5..8, data 0xA0..0xA3 on consecutive cycles -> rf_we=1 with matching addr/data one cycle later each, wb_stall never 1.
- LU-only: issue_reg=9; busy_a(src_a=9)=1 next cycle; push lu_reg=9 data 0xDEAD -> rf write to 9 two cycles after push, busy_a=0 after the pop edge.
- Starvation: FIFO holds reg 3, wb_valid held 1 -> W granted 3 cycles, 4th cycle wb_stall=1 and reg 3 written; W resumes next cycle.
- FIFO full: 2 LU pushes while W busy -> lu_ready=0; lu_valid held stays unaccepted until a pop, then accepted next cycle.
- Register 0: W and LU writes to reg 0 -> consumed, rf_we stays 0; issue_reg=0 never sets busy.
- Reset mid-operation: FIFO with 2 entries, scoreboard bits 4 and 7 set, assert reset asynchronously -> all outputs return to reset values before the next clock edge; no writes afterwards.
